// File: rtl/stream_arb2.sv
// stream_arb2: two-input valid/ready arbiter that drives the select line of an
// external 2:1 data mux. The mux output is captured into a one-entry output
// register, which has its own valid/ready handshake towards the downstream consumer.
//
// Build option: define STREAM_ARB2_RR_EN for round-robin tie-breaking.
// Without it, ties use fixed priority and stream A always wins.
module stream_arb2 #(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             sel,
    input  logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } out_state_e;

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;  // 1 = B was the most recent winner
    logic             sel_q, sel_d;
    logic             req_any;
    logic             grant_b;
    logic             can_load;
    logic             xfer;

    // Grant decision from the two valids and the last-winner pointer
    always_comb begin
        grant_b = 1'b0;
        case ({a_valid, b_valid})
            2'b01:   grant_b = 1'b1;
            2'b11: begin
`ifdef STREAM_ARB2_RR_EN
                grant_b = ~last_q;
`else
                grant_b = 1'b0;
`endif
            end
            default: grant_b = 1'b0;
        endcase
    end

    // Handshakes and the select line; readies are forced low while reset is held
    always_comb begin
        req_any  = a_valid | b_valid;
        can_load = rst_n & ((state_q == StEmpty) | out_ready);
        a_ready  = can_load & a_valid & ~grant_b;
        b_ready  = can_load & b_valid & grant_b;
        xfer     = a_ready | b_ready;
        // With no request, sel keeps pointing at the previous winner
        sel      = req_any ? grant_b : sel_q;
    end

    // Next state of the output register, pointers and transfer counter
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            // Covers both a fill from empty and a consume-and-reload on the same edge
            state_d = StFull;
            data_d  = mux_out;
            last_d  = grant_b;
            sel_d   = grant_b;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if ((state_q == StFull) && out_ready) begin
            state_d = StEmpty;
        end
    end

    // State registers; reset drops any held word immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs only; there is no combinational path from mux_out
    always_comb begin
        out_valid = (state_q == StFull);
        out_data  = data_q;
        xfer_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_stream_arb2.sv
// Testbench for stream_arb2. It models the external 2:1 mux and keeps a
// transaction-level reference model of the output register, the arbitration
// and the transfer counter. It runs directed steps and then randomized
// traffic that obeys the upstream hold rule.
module tb_stream_arb2;

    localparam int unsigned W  = 20;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, a_ready, b_ready, sel;
    logic [W-1:0]  a_data, b_data, mux_out, out_data;
    logic          out_valid, out_ready;
    logic [CW-1:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_last;   // 1 = B
    logic          m_sel;
    int            m_cnt;
    logic          acc_a, acc_b;

    always #5 clk = ~clk;

    // External mux
    assign mux_out = sel ? b_data : a_data;

    stream_arb2 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .sel       (sel),
        .mux_out   (mux_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner: -1 none, 0 A, 1 B
    function automatic int winner(input logic av, input logic bv, input logic last);
        if (av && !bv) return 0;
        if (bv && !av) return 1;
        if (!av) return -1;
`ifdef STREAM_ARB2_RR_EN
        return last ? 0 : 1;
`else
        return (last === 1'bx) ? 0 : 0;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b1;
        m_sel   = 1'b0;
        m_cnt   = 0;
        acc_a   = 1'b0;
        acc_b   = 1'b0;
    endtask

    // One clock: check the combinational outputs, take the edge, then check the registers
    task automatic cycle(input string tag);
        int   g;
        logic cl;
        #1;
        cl = !m_valid || out_ready;
        g  = winner(a_valid, b_valid, m_last);
        chk({tag, ".sel"}, 32'(sel), 32'((g < 0) ? m_sel : g[0]));
        chk({tag, ".a_ready"}, 32'(a_ready), 32'(cl && g == 0));
        chk({tag, ".b_ready"}, 32'(b_ready), 32'(cl && g == 1));
        acc_a = cl && g == 0;
        acc_b = cl && g == 1;
        @(posedge clk);
        if (acc_a || acc_b) begin
            m_data  = acc_b ? b_data : a_data;
            m_valid = 1'b1;
            m_last  = acc_b;
            m_sel   = acc_b;
            m_cnt   = (m_cnt + 1) % (1 << CW);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
        chk({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
    endtask

    initial begin
        // Reset held with both valids high
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        a_data = 20'h11111; b_data = 20'h22222;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.sel", 32'(sel), 32'd0);
        chk("rst.a_ready", 32'(a_ready), 32'd0);
        chk("rst.b_ready", 32'(b_ready), 32'd0);
        chk("rst.xfer_cnt", 32'(xfer_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source A, then single source B
        a_valid = 1'b1; b_valid = 1'b0; a_data = 20'hdecaf;
        cycle("single_a");
        chk("single_a.data", 32'(out_data), 32'hdecaf);
        chk("single_a.cnt", 32'(xfer_cnt), 32'd1);
        a_valid = 1'b0; b_valid = 1'b1; b_data = 20'hfaced;
        cycle("single_b");
        chk("single_b.sel", 32'(sel), 32'd1);
        chk("single_b.data", 32'(out_data), 32'hfaced);

        // Tie for four cycles
        a_valid = 1'b1; b_valid = 1'b1; a_data = 20'h0cafe; b_data = 20'h0face;
        for (int i = 0; i < 4; i++) begin
            cycle("tie");
`ifdef STREAM_ARB2_RR_EN
            chk("tie.seq", 32'(out_data), (i % 2 == 0) ? 32'h0cafe : 32'h0face);
`else
            chk("tie.seq", 32'(out_data), 32'h0cafe);
`endif
        end

        // Backpressure while FULL, then release
        out_ready = 1'b0; b_valid = 1'b0; a_valid = 1'b1; a_data = 20'h12345;
        for (int i = 0; i < 3; i++) cycle("bp");
        out_ready = 1'b1;
        cycle("bp_rel");
        chk("bp_rel.valid", 32'(out_valid), 32'd1);
        chk("bp_rel.data", 32'(out_data), 32'h12345);

        // Randomized traffic that respects the upstream hold rule
        for (int i = 0; i < 400; i++) begin
            if (!a_valid || acc_a) begin
                a_valid = 1'($urandom_range(0, 1));
                a_data  = 20'($urandom);
            end
            if (!b_valid || acc_b) begin
                b_valid = 1'($urandom_range(0, 1));
                b_data  = 20'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        // Counter wrap after a fresh reset
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_data = 20'(i);
            cycle("wrap");
        end
        chk("wrap.zero", 32'(xfer_cnt), 32'd0);
        chk("wrap.full", 32'(out_valid), 32'd1);

        // Asynchronous reset while FULL: out_valid drops before the next edge
        rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 32'd0);
        chk("async_rst.out_data", 32'(out_data), 32'd0);
        chk("async_rst.a_ready", 32'(a_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 1'b0;
        cycle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_arb2.md
# stream_arb2

Two-input valid/ready arbiter feeding the 2:1 data mux and registering its result. Each cycle it picks one requesting upstream stream, drives the mux `sel` line, and captures `mux_out` into a one-entry output register with a valid/ready interface to the downstream consumer. It sits directly around `mux2to1`:
- `a`/`b` data go straight from the sources into the mux.
- This block owns `sel`, the handshakes and the registered result.

## Interface
Parameters:
- `WIDTH`, 100, data width; matches the mux `a`/`b`/`out` width.
- `CNT_W`, 16, width of the transfer counter.

Ports:
- `clk`  input  1  single clock, rising-edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `a_valid`  input  1  stream A has data on mux input `a`.
- `a_ready`  output  1  stream A word accepted this cycle.
- `b_valid`  input  1  stream B has data on mux input `b`.
- `b_ready`  output  1  stream B word accepted this cycle.
- `sel`  output  1  mux select: 0 = `a`, 1 = `b`.
- `mux_out`  input  WIDTH  mux output, returned from `mux2to1.out`.
- `out_data`  output  WIDTH  registered result.
- `out_valid`  output  1  `out_data` holds an unconsumed word.
- `out_ready`  input  1  downstream accepts `out_data`.
- `xfer_cnt`  output  CNT_W  count of accepted input words.

## Operation
- The output register has two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `can_load` = EMPTY, or (FULL and `out_ready`).
- Grant is combinational from `a_valid`, `b_valid` and the `last` pointer:
  - Only one stream valid: that stream is granted.
  - Both valid: policy per Configuration.
  - Neither valid: no grant, and `sel` holds its previous value (registered `sel_q`).
- `sel` equals the grant whenever a grant exists.
- `a_ready` = `can_load` & grant==A. `b_ready` = `can_load` & grant==B. The two readies are never high together.
- Transfer occurs on a clock edge with `x_valid` & `x_ready` for stream x. On that edge:
  - `out_data` <= `mux_out`.
  - `out_valid` <= 1.
  - `last` <= x.
  - `sel_q` <= x.
  - `xfer_cnt` <= `xfer_cnt`+1. The counter wraps modulo 2^CNT_W; it does not saturate.
- Output consumed (FULL & `out_ready`) with no new transfer: `out_valid` <= 0 and `out_data` holds its value.
- Consume and transfer on the same edge: the register reloads and stays FULL. This gives 1 word/cycle throughput.
- FULL & !`out_ready`: both readies are 0, `out_data` is stable, and `sel` still follows the grant (no transfer occurs).
- Reset values: `out_valid`=0, `out_data`=0, `sel_q`=0, `last`=B (so A wins the first tie), `xfer_cnt`=0. The combinational readies are 0 while `rst_n`=0.
- Reset mid-operation: any held word is discarded, `out_valid` drops immediately and asynchronously, and no transfer is counted on that edge.

## Timing
- Latency: input transfer at edge N → `out_valid`=1 with that word's `out_data` from edge N through at least edge N+1.
- `sel` settles combinationally in the same cycle as valid. `mux_out` must be stable before the edge; the path is `sel` → mux → `mux_out` → register, one cycle.
- No combinational path from `mux_out` to any output.
- Readies depend combinationally on `out_ready`, the valids and `last`.
- Upstream rule: `x_valid` must not drop, and data must not change, until accepted.

## Configuration
- Macro `STREAM_ARB2_RR_EN`.
- Defined: round-robin. On a tie, the stream not equal to `last` wins. Under continuous dual requests with `out_ready`=1, grants strictly alternate.
- Undefined: fixed priority, A always wins a tie. `last` is still tracked but does not affect the grant.

## Test plan
- Reset: hold `rst_n`=0 with both valids high → `out_valid`=0, `out_data`=0, `sel`=0, both readies 0, `xfer_cnt`=0.
- Single source: `a_valid`=1, `a`=20'hdecaf, `out_ready`=1 → `sel`=0, `a_ready`=1. The cycle after the edge, `out_data`=0xdecaf and `xfer_cnt`=1. Then `b_valid` only with `b`=20'hfaced → `sel`=1 and `out_data`=0xfaced.
- Tie, with RR: both valid for 4 cycles, `a`=16'hcafe, `b`=16'hface, `out_ready`=1 → `out_data` sequence cafe, face, cafe, face.
- Tie, without RR: same stimulus → cafe ×4, `b_ready` never 1.
- Backpressure: FULL with `out_ready`=0 for 3 cycles and `a_valid`=1 → `a_ready`=0 and `out_data` unchanged. Raise `out_ready` → the A word transfers on that edge, `out_valid` stays 1 (simultaneous consume and load).
- Counter wrap and reset: with CNT_W=4, 16 transfers → `xfer_cnt`=0. Pulse `rst_n` low while FULL → `out_valid`=0 immediately, before the next edge.
